ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
Shares the single 64-bit, 8-byte-wide data RAM port between the instruction-fetch requester (IF, read-only) and the load/store requester (MEM).
- Sits between the IF/MEM pipeline stages and the RAM.
- Serialises requests with one outstanding RAM transaction.
- Handles a RAM with variable grant and response latency.
- Generates accept and response handshakes back to each requester.

Parameters:
- XLEN, 64: data and address width.
- STARVE_LIMIT, 4: consecutive MEM grants allowed while IF waits (only with the optional feature).
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req_i  in  1  IF read request; held with payload until if_gnt_o
- if_addr_i  in  XLEN  IF address, 8-byte aligned
- if_flush_i  in  1  cancels pending or in-flight IF request
- if_gnt_o  out  1  IF request accepted this cycle
- if_rvalid_o  out  1  IF read data valid, 1-cycle pulse
- if_rdata_o  out  XLEN  IF read data
- mem_req_i  in  1  MEM request; held with payload until mem_gnt_o
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  XLEN  MEM address, 8-byte aligned
- mem_byte_en_i  in  8  write byte enables
- mem_wdata_i  in  XLEN  write data, already lane-replicated
- mem_gnt_o  out  1  MEM request accepted this cycle
- mem_rvalid_o  out  1  MEM completion pulse (read data or write ack)
- mem_rdata_o  out  XLEN  MEM read data
- ram_req_o  out  1  RAM request, held until ram_gnt_i
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  XLEN  RAM address
- ram_byte_en_o  out  8  RAM byte enables; 8'hFF for reads
- ram_wdata_o  out  XLEN  RAM write data
- ram_gnt_i  in  1  RAM accepted request
- ram_rvalid_i  in  1  RAM response (read data or write done)
- ram_rdata_i  in  XLEN  RAM read data
- busy_o  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset: all outputs 0, state IDLE, owner/drop/counter cleared. Reset mid-transaction abandons it; the RAM shares rst.
- States:
  - IDLE: candidates are mem_req_i and (if_req_i & !if_flush_i). MEM wins, except when the optional feature forces IF. The winner's gnt_o is asserted combinationally in the same cycle. Owner, we, addr, byte_en, wdata are registered. Next state REQ. No candidate: stay IDLE, gnt_o = 0.
  - REQ: ram_req_o = 1 with the registered payload. On ram_gnt_i go to WAIT, or straight to RESP-complete if ram_rvalid_i arrives in the same cycle.
  - WAIT: ram_req_o = 0. On ram_rvalid_i, capture ram_rdata_i and return to IDLE.
- Response: owner's rvalid_o is a registered pulse, 1 cycle after ram_rvalid_i, with rdata held until the next response. The arbiter is in IDLE in that same cycle and can accept a new request (back-to-back).
- Minimum latency: gnt at cycle 0, ram_req cycles 1.., rvalid_o at 3 with a zero-wait RAM.
- Only one of if_gnt_o/mem_gnt_o is high in any cycle. At most one transaction is in flight.
- Flush: if_flush_i while IF owns REQ or WAIT sets the drop flag. The RAM transaction still completes, if_rvalid_o is suppressed, and drop clears on completion. if_flush_i has no effect on a MEM-owned transaction.
- Reads drive ram_byte_en_o = 8'hFF and ram_wdata_o = 0.
- ram_rvalid_i in IDLE or REQ without a grant: ignored. A ram_gnt_i in WAIT is ignored.

Optional Feature:
- Macro: RAM_ARB_STARVE_GUARD_EN.
- Defined:
  - CNT_W-bit counter increments on each MEM grant while IF is a candidate.
  - Counter clears on IF grant, and on any cycle with no IF candidate in IDLE.
  - When counter == STARVE_LIMIT and IF is a candidate, IF wins over MEM.
  - Counter saturates and never wraps.
- Undefined: strict MEM priority, no counter logic.

Decomposition:
- Shared defines header holds:
  - XLEN
  - state encodings ARB_IDLE/ARB_REQ/ARB_WAIT (2 bits)
  - owner encoding ARB_OWN_IF = 0, ARB_OWN_MEM = 1
- One sub-module, ram_arb_sel: combinational priority select plus the starvation counter. It outputs the winner and the grant vector, keeping the FSM/datapath separate.

Test Plan:
- Single IF read, addr 0x80, zero-wait RAM returning 0x1122334455667788 -> if_gnt_o at cycle 0, ram_req_o at cycle 1, if_rvalid_o at cycle 3 with that data; mem_rvalid_o stays 0.
- IF and MEM request in the same cycle, MEM write addr 0x100, byte_en 8'h0F -> mem_gnt_o first; ram_we_o = 1 with byte_en 0x0F; IF granted in the cycle mem_rvalid_o pulses.
- RAM holds ram_gnt_i low for 5 cycles -> ram_req_o and payload stable all 5 cycles; no gnt_o to either requester meanwhile.
- IF read in WAIT, if_flush_i pulsed, then ram_rvalid_i -> no if_rvalid_o; busy_o drops; a new IF request is granted the next cycle.
- With RAM_ARB_STARVE_GUARD_EN and STARVE_LIMIT = 4, mem_req_i and if_req_i held continuously -> grant order M,M,M,M,I,M,M,M,M,I; without the macro, all M.
- Assert rst while in WAIT -> all outputs 0 immediately; no rvalid pulse after release even if ram_rvalid_i arrives.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: data width, FSM state and
// owner encodings, and the byte-enable helper used when a request is latched.
package ram_port_arbiter_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  localparam logic ARB_OWN_IF  = 1'b0;
  localparam logic ARB_OWN_MEM = 1'b1;

  // Reads always present a full-width byte enable to the RAM.
  function automatic logic [7:0] arb_byte_en(input logic we, input logic [7:0] be);
    return we ? be : 8'hFF;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the IF requester, MEM requester and RAM port signals.
// slave = arbiter side, master = environment (requesters + RAM) side.
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;

  logic            if_req_i;
  logic [XLEN-1:0] if_addr_i;
  logic            if_flush_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [XLEN-1:0] if_rdata_o;

  logic            mem_req_i;
  logic            mem_we_i;
  logic [XLEN-1:0] mem_addr_i;
  logic [7:0]      mem_byte_en_i;
  logic [XLEN-1:0] mem_wdata_i;
  logic            mem_gnt_o;
  logic            mem_rvalid_o;
  logic [XLEN-1:0] mem_rdata_o;

  logic            ram_req_o;
  logic            ram_we_o;
  logic [XLEN-1:0] ram_addr_o;
  logic [7:0]      ram_byte_en_o;
  logic [XLEN-1:0] ram_wdata_o;
  logic            ram_gnt_i;
  logic            ram_rvalid_i;
  logic [XLEN-1:0] ram_rdata_i;

  logic            busy_o;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_byte_en_i, mem_wdata_i,
    output mem_gnt_o, mem_rvalid_o, mem_rdata_o,
    output ram_req_o, ram_we_o, ram_addr_o, ram_byte_en_o, ram_wdata_o,
    input  ram_gnt_i, ram_rvalid_i, ram_rdata_i,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output mem_req_i, mem_we_i, mem_addr_i, mem_byte_en_i, mem_wdata_i,
    input  mem_gnt_o, mem_rvalid_o, mem_rdata_o,
    input  ram_req_o, ram_we_o, ram_addr_o, ram_byte_en_o, ram_wdata_o,
    output ram_gnt_i, ram_rvalid_i, ram_rdata_i,
    input  busy_o
  );

endinterface

// File: rtl/ram_arb_sel.sv
// Priority select between IF and MEM candidates while the arbiter is idle.
// MEM has priority. With RAM_ARB_STARVE_GUARD_EN defined, a saturating
// counter of MEM grants taken while IF waits forces an IF grant once it
// reaches STARVE_LIMIT.
module ram_arb_sel
  import ram_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
`ifdef RAM_ARB_STARVE_GUARD_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic       i_idle,
  input  logic       i_if_cand,
  input  logic       i_mem_cand,
  output logic       o_winner,
  output logic [1:0] o_gnt
);

  // Static configuration guard: the counter must be able to hold STARVE_LIMIT.
  if ((2 ** CNT_W) <= STARVE_LIMIT) begin : g_cnt_w_check
    $error("ram_arb_sel: CNT_W too narrow for STARVE_LIMIT");
  end

  logic w_force_if;

`ifdef RAM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_force_if = i_if_cand && (r_cnt == CNT_W'(STARVE_LIMIT));

  // Starvation counter: count MEM grants while IF waits, clear when IF is served or absent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_idle) begin
      if (!i_if_cand || o_gnt[ARB_OWN_IF]) begin
        r_cnt <= '0;
      end else if (o_gnt[ARB_OWN_MEM] && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  // Winner selection; grants only exist in IDLE.
  always_comb begin
    o_winner = ARB_OWN_MEM;
    o_gnt    = 2'b00;
    if (i_idle) begin
      if (i_mem_cand && !w_force_if) begin
        o_winner              = ARB_OWN_MEM;
        o_gnt[ARB_OWN_MEM]    = 1'b1;
      end else if (i_if_cand) begin
        o_winner              = ARB_OWN_IF;
        o_gnt[ARB_OWN_IF]     = 1'b1;
      end else begin
        o_winner              = ARB_OWN_MEM;
      end
    end else begin
      o_gnt = 2'b00;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one 64-bit RAM port between the IF (read-only) and MEM requesters,
// one transaction in flight at a time. Optional macro
// RAM_ARB_STARVE_GUARD_EN bounds how long IF can be starved by MEM.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic          clk,
  input logic          rst,
  ram_port_arbiter_if.slave bus
);

  arb_state_e      r_state, w_next;
  logic            r_owner, r_we, r_drop;
  logic [XLEN-1:0] r_addr, r_wdata, r_if_rdata, r_mem_rdata;
  logic [7:0]      r_be;
  logic            r_if_rvalid, r_mem_rvalid;

  logic            w_idle, w_if_cand, w_winner, w_done, w_flush_hit, w_drop_eff;
  logic [1:0]      w_gnt;

  assign w_idle    = (r_state == ARB_IDLE);
  assign w_if_cand = bus.if_req_i & ~bus.if_flush_i;

  ram_arb_sel #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_sel (
`ifdef RAM_ARB_STARVE_GUARD_EN
    .clk        (clk),
    .rst        (rst),
`endif
    .i_idle     (w_idle),
    .i_if_cand  (w_if_cand),
    .i_mem_cand (bus.mem_req_i),
    .o_winner   (w_winner),
    .o_gnt      (w_gnt)
  );

  // A flush only matters while IF owns a live transaction; it may land on the completion cycle.
  assign w_flush_hit = bus.if_flush_i & (r_owner == ARB_OWN_IF) & ~w_idle;
  assign w_drop_eff  = r_drop | w_flush_hit;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; w_done marks the cycle the RAM response is consumed.
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (|w_gnt) w_next = ARB_REQ;
        else        w_next = ARB_IDLE;
      end
      ARB_REQ: begin
        if (bus.ram_gnt_i && bus.ram_rvalid_i) begin
          w_next = ARB_IDLE;
          w_done = 1'b1;
        end else if (bus.ram_gnt_i) begin
          w_next = ARB_WAIT;
        end else begin
          w_next = ARB_REQ;
        end
      end
      ARB_WAIT: begin
        if (bus.ram_rvalid_i) begin
          w_next = ARB_IDLE;
          w_done = 1'b1;
        end else begin
          w_next = ARB_WAIT;
        end
      end
      default: begin
        w_next = ARB_IDLE;
        w_done = 1'b0;
      end
    endcase
  end

  // Latch the winner's payload at grant time; reads carry full byte enables and zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= ARB_OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= 8'h00;
      r_wdata <= '0;
    end else if (w_idle && (|w_gnt)) begin
      r_owner <= w_winner;
      if (w_winner == ARB_OWN_MEM) begin
        r_we    <= bus.mem_we_i;
        r_addr  <= bus.mem_addr_i;
        r_be    <= arb_byte_en(bus.mem_we_i, bus.mem_byte_en_i);
        r_wdata <= bus.mem_we_i ? bus.mem_wdata_i : '0;
      end else begin
        r_we    <= 1'b0;
        r_addr  <= bus.if_addr_i;
        r_be    <= arb_byte_en(1'b0, 8'h00);
        r_wdata <= '0;
      end
    end
  end

  // Drop flag, response pulses and held read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop       <= 1'b0;
      r_if_rvalid  <= 1'b0;
      r_mem_rvalid <= 1'b0;
      r_if_rdata   <= '0;
      r_mem_rdata  <= '0;
    end else begin
      r_if_rvalid  <= w_done & (r_owner == ARB_OWN_IF) & ~w_drop_eff;
      r_mem_rvalid <= w_done & (r_owner == ARB_OWN_MEM);
      if (w_done) begin
        r_drop <= 1'b0;
      end else if (w_flush_hit) begin
        r_drop <= 1'b1;
      end
      if (w_done && (r_owner == ARB_OWN_IF) && !w_drop_eff) begin
        r_if_rdata <= bus.ram_rdata_i;
      end
      if (w_done && (r_owner == ARB_OWN_MEM)) begin
        r_mem_rdata <= bus.ram_rdata_i;
      end
    end
  end

  assign bus.if_gnt_o      = w_gnt[ARB_OWN_IF]  & ~rst;
  assign bus.mem_gnt_o     = w_gnt[ARB_OWN_MEM] & ~rst;
  assign bus.if_rvalid_o   = r_if_rvalid;
  assign bus.if_rdata_o    = r_if_rdata;
  assign bus.mem_rvalid_o  = r_mem_rvalid;
  assign bus.mem_rdata_o   = r_mem_rdata;
  assign bus.ram_req_o     = (r_state == ARB_REQ);
  assign bus.ram_we_o      = r_we;
  assign bus.ram_addr_o    = r_addr;
  assign bus.ram_byte_en_o = r_be;
  assign bus.ram_wdata_o   = r_wdata;
  assign bus.busy_o        = ~w_idle;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter. Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if bus ();

  ram_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_i = 1'b0;      bus.if_addr_i = '0;     bus.if_flush_i = 1'b0;
    bus.mem_req_i = 1'b0;     bus.mem_we_i = 1'b0;    bus.mem_addr_i = '0;
    bus.mem_byte_en_i = 8'h00; bus.mem_wdata_i = '0;
    bus.ram_gnt_i = 1'b0;     bus.ram_rvalid_i = 1'b0; bus.ram_rdata_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.if_req_i = 1'b1;
    bus.mem_req_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt_o, bus.mem_gnt_o, bus.ram_req_o, bus.busy_o, bus.if_rvalid_o, bus.mem_rvalid_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000", {bus.if_gnt_o, bus.mem_gnt_o, bus.ram_req_o, bus.busy_o, bus.if_rvalid_o, bus.mem_rvalid_o});
    end
    checks++;
    if ({bus.ram_addr_o, bus.ram_byte_en_o, bus.ram_we_o} !== 73'd0) begin
      failures++;
      $display("FAIL reset_ram got=%h exp=0", {bus.ram_addr_o, bus.ram_byte_en_o, bus.ram_we_o});
    end
    step();
    idle_inputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_if_read();
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h80;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt_o, bus.mem_gnt_o, bus.ram_req_o} !== 3'b100) begin
      failures++; $display("FAIL if_rd_c0 got=%b exp=100", {bus.if_gnt_o, bus.mem_gnt_o, bus.ram_req_o});
    end
    step();
    bus.if_req_i = 1'b0; bus.ram_gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_byte_en_o, bus.ram_wdata_o} !== {1'b1, 1'b0, 64'h80, 8'hFF, 64'h0}) begin
      failures++; $display("FAIL if_rd_c1 req=%b we=%b addr=%h be=%h exp 1 0 80 ff", bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_byte_en_o);
    end
    step();
    bus.ram_gnt_i = 1'b0; bus.ram_rvalid_i = 1'b1; bus.ram_rdata_i = 64'h1122334455667788;
    @(negedge clk);
    checks++;
    if ({bus.ram_req_o, bus.busy_o, bus.if_rvalid_o} !== 3'b010) begin
      failures++; $display("FAIL if_rd_c2 got=%b exp=010", {bus.ram_req_o, bus.busy_o, bus.if_rvalid_o});
    end
    step();
    bus.ram_rvalid_i = 1'b0; bus.ram_rdata_i = '0;
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid_o, bus.mem_rvalid_o, bus.busy_o, bus.if_rdata_o} !== {3'b100, 64'h1122334455667788}) begin
      failures++; $display("FAIL if_rd_c3 rv=%b mrv=%b busy=%b data=%h exp 1 0 0 1122334455667788", bus.if_rvalid_o, bus.mem_rvalid_o, bus.busy_o, bus.if_rdata_o);
    end
    step();
    checks++;
    if (bus.if_rvalid_o !== 1'b0) begin
      failures++; $display("FAIL if_rd_pulse got=%b exp=0", bus.if_rvalid_o);
    end
  endtask

  task automatic test_mem_priority();
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h180;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 64'h100;
    bus.mem_byte_en_i = 8'h0F; bus.mem_wdata_i = 64'hAAAA_5555_1234_5678;
    @(negedge clk);
    checks++;
    if ({bus.mem_gnt_o, bus.if_gnt_o} !== 2'b10) begin
      failures++; $display("FAIL prio_gnt got=%b exp=10", {bus.mem_gnt_o, bus.if_gnt_o});
    end
    step();
    bus.mem_req_i = 1'b0; bus.ram_gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_byte_en_o, bus.ram_wdata_o} !== {1'b1, 1'b1, 64'h100, 8'h0F, 64'hAAAA_5555_1234_5678}) begin
      failures++; $display("FAIL prio_wr we=%b addr=%h be=%h wd=%h exp 1 100 0f aaaa555512345678", bus.ram_we_o, bus.ram_addr_o, bus.ram_byte_en_o, bus.ram_wdata_o);
    end
    step();
    bus.ram_gnt_i = 1'b0; bus.ram_rvalid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.if_gnt_o !== 1'b0) begin
      failures++; $display("FAIL prio_wait_gnt got=%b exp=0", bus.if_gnt_o);
    end
    step();
    bus.ram_rvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_rvalid_o, bus.if_gnt_o, bus.if_rvalid_o, bus.mem_gnt_o} !== 4'b1100) begin
      failures++; $display("FAIL prio_b2b got=%b exp=1100", {bus.mem_rvalid_o, bus.if_gnt_o, bus.if_rvalid_o, bus.mem_gnt_o});
    end
    step();
    bus.if_req_i = 1'b0; bus.ram_gnt_i = 1'b1; bus.ram_rvalid_i = 1'b1; bus.ram_rdata_i = 64'hCAFE_0000_BEEF_0001;
    @(negedge clk);
    checks++;
    if ({bus.ram_we_o, bus.ram_addr_o, bus.ram_byte_en_o, bus.ram_wdata_o} !== {1'b0, 64'h180, 8'hFF, 64'h0}) begin
      failures++; $display("FAIL prio_if_rd we=%b addr=%h be=%h wd=%h exp 0 180 ff 0", bus.ram_we_o, bus.ram_addr_o, bus.ram_byte_en_o, bus.ram_wdata_o);
    end
    step();
    bus.ram_gnt_i = 1'b0; bus.ram_rvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid_o, bus.mem_rvalid_o, bus.if_rdata_o} !== {2'b10, 64'hCAFE_0000_BEEF_0001}) begin
      failures++; $display("FAIL prio_same_cycle rv=%b mrv=%b data=%h exp 1 0 cafe0000beef0001", bus.if_rvalid_o, bus.mem_rvalid_o, bus.if_rdata_o);
    end
    step();
  endtask

  task automatic test_gnt_stall();
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 64'h200;
    bus.mem_byte_en_i = 8'hF0; bus.mem_wdata_i = 64'h0102_0304_0506_0708;
    step();
    bus.mem_req_i = 1'b0; bus.if_req_i = 1'b1; bus.if_addr_i = 64'h280;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.ram_req_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_byte_en_o, bus.ram_wdata_o, bus.if_gnt_o, bus.mem_gnt_o} !== {2'b11, 64'h200, 8'hF0, 64'h0102_0304_0506_0708, 2'b00}) begin
        failures++; $display("FAIL stall_c%0d req=%b addr=%h be=%h gnt=%b%b exp 1 200 f0 00", c, bus.ram_req_o, bus.ram_addr_o, bus.ram_byte_en_o, bus.if_gnt_o, bus.mem_gnt_o);
      end
      step();
    end
    bus.if_req_i = 1'b0; bus.ram_gnt_i = 1'b1; bus.ram_rvalid_i = 1'b1;
    step();
    bus.ram_gnt_i = 1'b0; bus.ram_rvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_rvalid_o, bus.busy_o} !== 2'b10) begin
      failures++; $display("FAIL stall_done got=%b exp=10", {bus.mem_rvalid_o, bus.busy_o});
    end
    step();
  endtask

  task automatic test_flush();
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h300;
    step();
    bus.if_req_i = 1'b0; bus.ram_gnt_i = 1'b1;
    step();
    bus.ram_gnt_i = 1'b0; bus.if_flush_i = 1'b1;
    step();
    bus.if_flush_i = 1'b0; bus.ram_rvalid_i = 1'b1; bus.ram_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h308;
    @(negedge clk);
    checks++;
    if (bus.if_gnt_o !== 1'b0) begin
      failures++; $display("FAIL flush_wait_gnt got=%b exp=0", bus.if_gnt_o);
    end
    step();
    bus.ram_rvalid_i = 1'b0; bus.ram_rdata_i = '0;
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid_o, bus.busy_o, bus.if_gnt_o} !== 3'b001) begin
      failures++; $display("FAIL flush_drop got=%b exp=001", {bus.if_rvalid_o, bus.busy_o, bus.if_gnt_o});
    end
    checks++;
    if (bus.if_rdata_o !== 64'hCAFE_0000_BEEF_0001) begin
      failures++; $display("FAIL flush_hold got=%h exp=cafe0000beef0001", bus.if_rdata_o);
    end
    step();
    bus.if_req_i = 1'b0; bus.ram_gnt_i = 1'b1; bus.ram_rvalid_i = 1'b1; bus.ram_rdata_i = 64'h0000_1111_2222_3333;
    step();
    bus.ram_gnt_i = 1'b0; bus.ram_rvalid_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.if_rvalid_o, bus.if_rdata_o} !== {1'b1, 64'h0000_1111_2222_3333}) begin
      failures++; $display("FAIL flush_next rv=%b data=%h exp 1 0000111122223333", bus.if_rvalid_o, bus.if_rdata_o);
    end
    step();
  endtask

  task automatic test_starve();
    logic exp_mem;
    logic found;
    logic got_mem;
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h400;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 64'h500;
    bus.ram_gnt_i = 1'b1; bus.ram_rvalid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
`ifdef RAM_ARB_STARVE_GUARD_EN
      exp_mem = ((i % 5) != 4);
`else
      exp_mem = 1'b1;
`endif
      found = 1'b0;
      got_mem = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus.if_gnt_o || bus.mem_gnt_o) begin
          found = 1'b1;
          got_mem = bus.mem_gnt_o;
          break;
        end
      end
      checks++;
      if (!found || (got_mem !== exp_mem) || (bus.if_gnt_o === bus.mem_gnt_o)) begin
        failures++; $display("FAIL starve_g%0d found=%b mem=%b if=%b exp_mem=%b", i, found, bus.mem_gnt_o, bus.if_gnt_o, exp_mem);
      end
    end
    step();
    bus.if_req_i = 1'b0; bus.mem_req_i = 1'b0;
    step();
    bus.ram_gnt_i = 1'b0; bus.ram_rvalid_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.if_req_i = 1'b1; bus.if_addr_i = 64'h600;
    step();
    bus.if_req_i = 1'b0; bus.ram_gnt_i = 1'b1;
    step();
    bus.ram_gnt_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b1) begin
      failures++; $display("FAIL rstmid_wait got=%b exp=1", bus.busy_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy_o, bus.ram_req_o, bus.if_rvalid_o, bus.ram_addr_o, bus.ram_byte_en_o} !== 75'd0) begin
      failures++; $display("FAIL rstmid_async busy=%b req=%b addr=%h be=%h exp 0", bus.busy_o, bus.ram_req_o, bus.ram_addr_o, bus.ram_byte_en_o);
    end
    step();
    rst = 1'b0; bus.ram_rvalid_i = 1'b1; bus.ram_rdata_i = 64'h7777_7777_7777_7777;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.if_rvalid_o, bus.mem_rvalid_o, bus.busy_o} !== 3'b000) begin
        failures++; $display("FAIL rstmid_post%0d got=%b exp=000", c, {bus.if_rvalid_o, bus.mem_rvalid_o, bus.busy_o});
      end
      step();
    end
    bus.ram_rvalid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_if_read();
    test_mem_priority();
    test_gnt_stall();
    test_flush();
    test_starve();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
